// File: rtl/mips_rf_pkg.sv
// Shared types and default dimensions for the multiport register file.
package mips_rf_pkg;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;

endpackage

// File: rtl/multiport_reg_file_if.sv
// Decode/writeback side bus of the register file: packed write ports, read ports and status.
interface multiport_reg_file_if
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     ready;
    logic                     err_zero_wr;
    logic                     err_collide;
    logic                     err_clear;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, err_clear,
        input  rd_data, ready, err_zero_wr, err_collide
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, err_clear,
        output rd_data, ready, err_zero_wr, err_collide
    );
endinterface

// File: rtl/rf_init_ctrl.sv
// INIT/RUN sequencer: after reset walks init_ptr over every entry, then raises ready.
module rf_init_ctrl
    import mips_rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);
    // One extra bit so the pointer never wraps onto entry 0 after the last clear.
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'((1 << ADDR_W) - 1);

    rf_state_t       state_q;
    logic [ADDR_W:0] init_ptr_q;
    logic            ready_q;

    // Sequencer state, clear pointer and registered ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RF_INIT;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                RF_INIT: begin
                    init_ptr_q <= init_ptr_q + (ADDR_W+1)'(1);
                    if (init_ptr_q == LAST_PTR) begin
                        state_q <= RF_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= RF_INIT;
                        ready_q <= 1'b0;
                    end
                end
                RF_RUN: begin
                    state_q <= RF_RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= RF_INIT;
                    init_ptr_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign init_we   = (state_q == RF_INIT);
    assign init_addr = init_ptr_q[ADDR_W-1:0];

endmodule

// File: rtl/multiport_reg_file.sv
// Multi-port register file with sequenced clear, priority write ports, optional bypass
// and sticky write-error flags.
module multiport_reg_file
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                 clock,
    input logic                 reset,
    multiport_reg_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              run_s;
    logic              init_we_s;
    logic [ADDR_W-1:0] init_addr_s;
    logic [NUM_WR-1:0] wr_live_s;
    logic              zero_wr_s;
    logic              collide_s;
    logic              err_zero_wr_q;
    logic              err_collide_q;

    rf_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clock     (clock),
        .reset     (reset),
        .ready     (run_s),
        .init_we   (init_we_s),
        .init_addr (init_addr_s)
    );

    // Qualify write ports: RUN only, and entry-0 writes are dropped when it is hardwired.
    always_comb begin
        wr_live_s = '0;
        zero_wr_s = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            if ((ZERO_REG != 0) && (bus.wr_addr[i*ADDR_W +: ADDR_W] == '0)) begin
                zero_wr_s = zero_wr_s | (run_s & bus.wr_en[i]);
            end else begin
                wr_live_s[i] = run_s & ~reset & bus.wr_en[i];
            end
        end
    end

    // Any two surviving write ports aimed at the same entry.
    always_comb begin
        collide_s = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int k = i + 1; k < NUM_WR; k++) begin
                collide_s = collide_s | (wr_live_s[i] & wr_live_s[k] &
                            (bus.wr_addr[i*ADDR_W +: ADDR_W] == bus.wr_addr[k*ADDR_W +: ADDR_W]));
            end
        end
    end

    // Storage update; later ports overwrite earlier ones, giving the highest index priority.
    always_ff @(posedge clock) begin
        if (init_we_s) begin
            mem_q[init_addr_s] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_live_s[i]) begin
                    mem_q[bus.wr_addr[i*ADDR_W +: ADDR_W]] <= bus.wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_zero_wr_q <= 1'b0;
            err_collide_q <= 1'b0;
        end else begin
            err_zero_wr_q <= zero_wr_s | (err_zero_wr_q & ~bus.err_clear);
            err_collide_q <= collide_s | (err_collide_q & ~bus.err_clear);
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr_s;
        logic [DATA_W-1:0] rd_val_s;

        assign rd_addr_s = bus.rd_addr[j*ADDR_W +: ADDR_W];

        // Read mux: array value, overridden by the highest-index matching write when bypassing.
        always_comb begin
            rd_val_s = mem_q[rd_addr_s];
            if (!run_s) begin
                rd_val_s = '0;
            end else if ((ZERO_REG != 0) && (rd_addr_s == '0)) begin
                rd_val_s = '0;
            end else begin
                for (int i = 0; i < NUM_WR; i++) begin
                    rd_val_s = ((BYPASS != 0) && bus.wr_en[i] &&
                                (bus.wr_addr[i*ADDR_W +: ADDR_W] == rd_addr_s))
                               ? bus.wr_data[i*DATA_W +: DATA_W] : rd_val_s;
                end
            end
        end

        assign bus.rd_data[j*DATA_W +: DATA_W] = rd_val_s;
    end

    assign bus.ready       = run_s;
    assign bus.err_zero_wr = err_zero_wr_q;
    assign bus.err_collide = err_collide_q;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed bench: dut_a (2 write ports, zero reg, bypass) and dut_b (1 write port, no zero reg, no bypass).
module tb_multiport_reg_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   n;
    int   bad;

    always #5 clk = ~clk;

    multiport_reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) ia ();
    multiport_reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1)) ib ();

    multiport_reg_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (ia.slave)
    );

    multiport_reg_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (ib.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        ia.wr_en = '0; ia.wr_addr = '0; ia.wr_data = '0; ia.rd_addr = '0; ia.err_clear = 1'b0;
        ib.wr_en = '0; ib.wr_addr = '0; ib.wr_data = '0; ib.rd_addr = '0; ib.err_clear = 1'b0;

        // 1: one reset cycle, then 32 clear cycles before ready
        tick();
        rst = 1'b0;
        ia.rd_addr = {5'd9, 5'd5};
        #1;
        chk("init_rd_forced0", ia.rd_data[31:0], 32'h0);
        chk("init_flags", {30'd0, ia.err_zero_wr, ia.err_collide}, 32'h0);
        n = 0;
        while (!ia.ready && n < 100) begin
            n++;
            tick();
        end
        chk("ready_latency", n, 32'd32);
        chk("ready_b", {31'd0, ib.ready}, 32'h1);
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            ia.rd_addr = {5'(31 - a), 5'(a)};
            ib.rd_addr = {5'(31 - a), 5'(a)};
            #1;
            if (ia.rd_data !== 64'h0 || ib.rd_data !== 64'h0) bad++;
        end
        chk("all_entries_zero", bad, 32'd0);

        // 2: same-cycle bypass on dut_a, next-cycle visibility on dut_b
        ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd5}; ia.wr_data = {32'h0, 32'hDEADBEEF};
        ib.wr_en = 1'b1;  ib.wr_addr = 5'd5;         ib.wr_data = 32'hDEADBEEF;
        ia.rd_addr = {5'd1, 5'd5};
        ib.rd_addr = {5'd1, 5'd5};
        #1;
        chk("bypass_same_cycle", ia.rd_data[31:0], 32'hDEADBEEF);
        chk("nobypass_old", ib.rd_data[31:0], 32'h0);
        tick();
        ia.wr_en = '0; ib.wr_en = '0;
        #1;
        chk("nobypass_next", ib.rd_data[31:0], 32'hDEADBEEF);
        chk("stored_a", ia.rd_data[31:0], 32'hDEADBEEF);

        // 3: two ports hit entry 7; port 1 wins and err_collide sets
        ia.wr_en = 2'b11; ia.wr_addr = {5'd7, 5'd7}; ia.wr_data = {32'h22, 32'h11};
        ia.rd_addr = {5'd7, 5'd0};
        #1;
        chk("bypass_priority", ia.rd_data[63:32], 32'h22);
        chk("collide_not_yet", {31'd0, ia.err_collide}, 32'h0);
        tick();
        ia.wr_en = '0;
        #1;
        chk("collide_set", {31'd0, ia.err_collide}, 32'h1);
        chk("entry7_winner", ia.rd_data[63:32], 32'h22);
        ia.err_clear = 1'b1;
        tick();
        ia.err_clear = 1'b0;
        #1;
        chk("collide_cleared", {31'd0, ia.err_collide}, 32'h0);

        // 4/7: entry-0 writes; dut_a hardwired zero, dut_b ordinary register
        ia.wr_en = 2'b11; ia.wr_addr = {5'd0, 5'd0}; ia.wr_data = {32'h12345678, 32'hFFFFFFFF};
        ia.rd_addr = {5'd7, 5'd0};
        ib.wr_en = 1'b1;  ib.wr_addr = 5'd0;         ib.wr_data = 32'hA5;
        ib.rd_addr = {5'd5, 5'd0};
        #1;
        chk("zero_rd_bypass", ia.rd_data[31:0], 32'h0);
        chk("b_zero_old", ib.rd_data[31:0], 32'h0);
        tick();
        ia.wr_en = '0; ib.wr_en = '0;
        #1;
        chk("zero_wr_set", {31'd0, ia.err_zero_wr}, 32'h1);
        chk("zero_no_collide", {31'd0, ia.err_collide}, 32'h0);
        chk("zero_rd_after", ia.rd_data[31:0], 32'h0);
        chk("b_entry0", ib.rd_data[31:0], 32'hA5);
        chk("b_no_zero_flag", {31'd0, ib.err_zero_wr}, 32'h0);
        ia.err_clear = 1'b1;
        ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd0};
        tick();
        ia.wr_en = '0;
        #1;
        chk("set_beats_clear", {31'd0, ia.err_zero_wr}, 32'h1);
        tick();
        ia.err_clear = 1'b0;
        #1;
        chk("zero_wr_cleared", {31'd0, ia.err_zero_wr}, 32'h0);

        // 5: write entry 3, then reset mid-RUN; writes during INIT are ignored
        ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd3}; ia.wr_data = {32'h0, 32'h5};
        tick();
        ia.wr_en = '0;
        ia.rd_addr = {5'd5, 5'd3};
        #1;
        chk("entry3_written", ia.rd_data[31:0], 32'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (19) tick();
        ia.wr_en = 2'b11; ia.wr_addr = {5'd3, 5'd3}; ia.wr_data = {32'h88, 32'h77};
        #1;
        chk("mid_init_ready", {31'd0, ia.ready}, 32'h0);
        chk("mid_init_rd", ia.rd_data[31:0], 32'h0);
        tick();
        ia.wr_en = '0;
        #1;
        chk("init_no_flag", {30'd0, ia.err_zero_wr, ia.err_collide}, 32'h0);
        n = 0;
        while (!ia.ready && n < 100) begin
            n++;
            tick();
        end
        chk("reinit_remaining", n, 32'd12);

        // 6: contents lost after the re-clear
        #1;
        chk("entry3_cleared", ia.rd_data[31:0], 32'h0);
        chk("entry5_cleared", ia.rd_data[63:32], 32'h0);
        chk("b_entry0_cleared", ib.rd_data[31:0], 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
